// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - instruction field positions shared by the decode stage
package decode_pkg;
   localparam int INSTR_W = 32;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two asynchronous read ports, one synchronous write port
// R0 is hardwired to zero; reset clears every entry.
module regfile_2r1w #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [REG_AW-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);
   localparam int DEPTH = 2 ** REG_AW;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_a_data = (rd_a_addr == '0) ? '0 : mem[rd_a_addr];
   assign rd_b_data = (rd_b_addr == '0) ? '0 : mem[rd_b_addr];
endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode stage: field split, operand read, imm sign-extend, one output register
// Build option DECODE_BYPASS_EN: writeback forwarded into loading and held entries.
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16,
   parameter int PC_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   input  logic [PC_W-1:0]    pc_in,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [REG_AW-1:0]  wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pc_out,
   output logic [DATA_W-1:0]  dataA_out,
   output logic [DATA_W-1:0]  dataB_out,
   output logic [DATA_W-1:0]  sign_extend_out,
   output logic [REG_AW-1:0]  rd_out,
   output logic [REG_AW-1:0]  rs_out,
   output logic [REG_AW-1:0]  rt_out
);
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              load;
   logic              unused_instr;

   assign rs       = instruction[RS_LSB +: REG_AW];
   assign rt       = instruction[RT_LSB +: REG_AW];
   assign rd       = instruction[RD_LSB +: REG_AW];
   assign imm      = instruction[IMM_W-1:0];
   assign imm_sext = DATA_W'(signed'(imm));
   // opcode/funct bits are decoded downstream, not here
   assign unused_instr = ^instruction;

   regfile_2r1w #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_a_addr (rs),
      .rd_a_data (rf_a),
      .rd_b_addr (rt),
      .rd_b_data (rf_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

`ifdef DECODE_BYPASS_EN
   assign op_a = (wr_en && (wr_addr == rs) && (rs != '0)) ? wr_data : rf_a;
   assign op_b = (wr_en && (wr_addr == rt) && (rt != '0)) ? wr_data : rf_b;
`else
   assign op_a = rf_a;
   assign op_b = rf_b;
`endif

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         pc_out          <= '0;
         dataA_out       <= '0;
         dataB_out       <= '0;
         sign_extend_out <= '0;
         rd_out          <= '0;
         rs_out          <= '0;
         rt_out          <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid       <= 1'b1;
         pc_out          <= pc_in;
         dataA_out       <= op_a;
         dataB_out       <= op_b;
         sign_extend_out <= imm_sext;
         rd_out          <= rd;
         rs_out          <= rs;
         rt_out          <= rt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else if (out_valid) begin
`ifdef DECODE_BYPASS_EN
         // a stalled entry tracks writebacks to its source registers
         if (wr_en && (wr_addr == rs_out) && (rs_out != '0)) begin
            dataA_out <= wr_data;
         end
         if (wr_en && (wr_addr == rt_out) && (rt_out != '0)) begin
            dataB_out <= wr_data;
         end
`endif
      end
   end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] pc_in;
   logic        flush;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [31:0] dataA_out;
   logic [31:0] dataB_out;
   logic [31:0] sign_extend_out;
   logic [4:0]  rd_out;
   logic [4:0]  rs_out;
   logic [4:0]  rt_out;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sx;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [4:0]  rt;
   } exp_t;

   exp_t        q[$];
   bit          mvalid;
   logic [31:0] regs[32];
   int          checks;
   int          failures;

   decode_stage_pipe #(
      .DATA_W (32),
      .REG_AW (5),
      .IMM_W  (16),
      .PC_W   (32)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .instruction     (instruction),
      .pc_in           (pc_in),
      .flush           (flush),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .pc_out          (pc_out),
      .dataA_out       (dataA_out),
      .dataB_out       (dataB_out),
      .sign_extend_out (sign_extend_out),
      .rd_out          (rd_out),
      .rs_out          (rs_out),
      .rt_out          (rt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                    input bit we, input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      int   s;
      int   t;
      int   imm;
      int   sv;
      s   = int'((ins >> 21) & 32'h1f);
      t   = int'((ins >> 16) & 32'h1f);
      imm = int'(ins & 32'hffff);
      sv  = (imm >= 32768) ? imm - 65536 : imm;
      e.pc = pc;
      e.rs = 5'(s);
      e.rt = 5'(t);
      e.rd = 5'((ins >> 11) & 32'h1f);
      e.sx = 32'(sv);
      e.a  = (s == 0) ? 32'h0 : regs[s];
      e.b  = (t == 0) ? 32'h0 : regs[t];
`ifdef DECODE_BYPASS_EN
      if (we && s != 0 && int'(wa) == s) e.a = wd;
      if (we && t != 0 && int'(wa) == t) e.b = wd;
`else
      if (we && wa == 5'd31 && wd == 32'h0) e.a = e.a;
`endif
      return e;
   endfunction

   // reference model: state after each rising edge, evaluated just before it
   always @(negedge clk) begin
      bit   rdy;
      exp_t h;
      #1;
      if (!rst_n) begin
         q.delete();
         mvalid = 1'b0;
         for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      end else begin
         rdy = !mvalid || out_ready;
         if (flush) begin
            q.delete();
            mvalid = 1'b0;
         end else if (in_valid && rdy) begin
            q.push_back(predict(instruction, pc_in, wr_en, wr_addr, wr_data));
            mvalid = 1'b1;
         end else if (out_ready) begin
            mvalid = 1'b0;
         end else if (q.size() != 0) begin
            h = q[0];
`ifdef DECODE_BYPASS_EN
            if (wr_en && wr_addr != 0 && wr_addr == h.rs) h.a = wr_data;
            if (wr_en && wr_addr != 0 && wr_addr == h.rt) h.b = wr_data;
`endif
            q[0] = h;
         end
         if (wr_en && wr_addr != 0) regs[wr_addr] = wr_data;
      end
   end

   // monitor: compares the handshake and every entry execute accepts
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (rst_n) begin
         check("out_valid", out_valid, mvalid);
         check("in_ready", in_ready, !mvalid || out_ready);
         if (out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL accept_unexpected actual=pc %0h required=no entry", pc_out);
            end else begin
               e   = q.pop_front();
               got = '{pc_out, dataA_out, dataB_out, sign_extend_out, rd_out, rs_out, rt_out};
               check("accept", got, e);
            end
         end
      end
   end

   task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc, input bit fl,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd, input bit ordy);
      in_valid    = iv;
      instruction = ins;
      pc_in       = pc;
      flush       = fl;
      wr_en       = we;
      wr_addr     = wa;
      wr_data     = wd;
      out_ready   = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ins;
      logic [31:0] exp_a;
      logic [31:0] exp_r;
      checks   = 0;
      failures = 0;
      rst_n = 1'b0;
      in_valid = 0; instruction = 0; pc_in = 0; flush = 0;
      wr_en = 0; wr_addr = 0; wr_data = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {pc_out, dataA_out, dataB_out, sign_extend_out, rd_out, rs_out, rt_out}, 0);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);

      drive(0, 0, 0, 0, 1, 5'd1, 32'h01234567, 1);
      drive(1, 32'h10215678, 32'h8, 0, 0, 0, 0, 0);
      check("t2_valid", out_valid, 1);
      check("t2_dataA", dataA_out, 32'h01234567);
      check("t2_dataB", dataB_out, 32'h01234567);
      check("t2_sext", sign_extend_out, 32'h00005678);
      check("t2_rd", rd_out, 5'h0A);
      check("t2_pc", pc_out, 32'h8);

      drive(0, 0, 0, 0, 1, 5'd0, 32'h0000DEAD, 1);
      drive(1, 32'h00008001, 32'hC, 0, 0, 0, 0, 0);
      check("t3_sext", sign_extend_out, 32'hFFFF8001);
      check("t3_r0", dataA_out, 32'h0);

      drive(1, 32'h10215678, 32'h100, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, $urandom, 32'h104, 0, 0, 0, 0, 0);
         check("t4_stall_valid", out_valid, 1);
         check("t4_stall_in_ready", in_ready, 0);
         check("t4_stall_pc", pc_out, 32'h100);
      end
      drive(1, $urandom, 32'h104, 0, 0, 0, 0, 1);
      check("t4_nobubble_valid", out_valid, 1);
      check("t4_nobubble_pc", pc_out, 32'h104);

      drive(1, $urandom, 32'h108, 0, 0, 0, 0, 0);
      drive(1, $urandom, 32'h10C, 1, 0, 0, 0, 0);
      check("t5_flush_valid", out_valid, 0);
      check("t5_flush_in_ready", in_ready, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1);

      drive(1, 32'h10215678, 32'h200, 0, 1, 5'd1, 32'hAAAA0000, 0);
`ifdef DECODE_BYPASS_EN
      exp_a = 32'hAAAA0000;
      exp_r = 32'h5555AAAA;
`else
      exp_a = 32'h01234567;
      exp_r = 32'h01234567;
`endif
      check("t6_load_bypass", dataA_out, exp_a);
      drive(0, 0, 0, 0, 1, 5'd1, 32'h5555AAAA, 0);
      check("t6_refresh_a", dataA_out, exp_r);
      check("t6_refresh_b", dataB_out, exp_r);
      drive(0, 0, 0, 0, 0, 0, 0, 1);

      drive(1, 32'h10215678, 32'h300, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_outputs", {pc_out, dataA_out, dataB_out, sign_extend_out, rd_out, rs_out, rt_out}, 0);
      #9 rst_n = 1'b1;
      #1;
      check("midrst_in_ready", in_ready, 1);
      drive(1, 32'h10215678, 32'h304, 0, 0, 0, 0, 0);
      check("midrst_rf_cleared", dataA_out, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 1500; i++) begin
         ins = $urandom;
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 9) < 7, ins, $urandom, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 9) < 7);
      end

      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
      check("drain_valid", out_valid, 0);
      check("drain_queue", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
